stopwatch_controller: RTL and testbench
=======================================

Name: stopwatch_controller

Overview:
- Sequences the 4-digit stopwatch time counter (digit order M:SS.t, i.e. d3 minutes, d2 tens of seconds mod 6, d1 seconds, d0 tenths).
- Generates the tenth-second count enable from the system clock and debounces the start/stop, lap and clear buttons.
- Runs the run/stop/lap state machine, issues counter clears and freezes the displayed value on lap.
- Sits between the board buttons and the time counter / display driver.

Parameters:
TICK_DIV, 10000000, clock cycles per count tick (100 MHz -> 10 Hz); legal range >= 2
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples needed to accept a button level; legal range >= 1
MAX_DIGITS, 16'h9599, BCD value at which counting stops (9:59.9)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
btn_startstop  input  1  raw start/stop button, active-high, asynchronous
btn_lap  input  1  raw lap button, active-high, asynchronous
btn_clear  input  1  raw clear button, active-high, asynchronous
digits_in  input  16  live BCD count from the time counter {d3,d2,d1,d0}
count_enable  output  1  one-cycle increment strobe to the time counter
count_clear  output  1  one-cycle clear strobe to the time counter
digits_out  output  16  value to display: live count, or the latched lap value
running  output  1  high in RUN and LAP
lapping  output  1  high in LAP

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; prescaler, debouncers and lap register = 0.
  - count_enable = 0, count_clear = 0, running = 0, lapping = 0.
  - digits_out follows digits_in.
- Button path, one instance per button:
  - 2-flop synchroniser.
  - Debounce counter resets on any change of the synchronised level. The accepted level updates when the level has been stable for DEBOUNCE_CYCLES samples.
  - Each 0->1 transition of the accepted level produces a one-cycle press pulse (ss_p, lap_p, clr_p). Holding a button produces exactly one pulse.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and LAP, and holds its value in IDLE and STOPPED, so a fractional tenth is preserved across stop/start.
  - tick = 1 for one cycle when the count is TICK_DIV-1; the count then wraps to 0.
- count_enable:
  - count_enable = tick while in RUN or LAP, registered so it is a single clean cycle.
  - If tick occurs while digits_in == MAX_DIGITS, count_enable is suppressed and the state goes to STOPPED (saturation: never wraps past 9:59.9).
- State transitions (evaluated on press pulses, registered):
  - IDLE: ss_p -> RUN. clr_p -> pulse count_clear and clear the prescaler, stay IDLE. lap_p ignored.
  - RUN: ss_p -> STOPPED. lap_p -> LAP and capture digits_in into the lap register that cycle. clr_p ignored.
  - LAP: lap_p -> RUN and release the display. ss_p -> STOPPED and release the display. clr_p ignored. Counting continues underneath.
  - STOPPED: ss_p -> RUN. clr_p -> IDLE, pulse count_clear for one cycle and zero the prescaler. lap_p ignored.
- Simultaneous pulses in the same cycle: ss_p has priority over lap_p, which has priority over clr_p. The lower-priority pulses are discarded, not queued.
- count_clear is asserted exactly one cycle, the cycle after the accepted clr_p, and never in the same cycle as count_enable.
- digits_out = lap register in LAP, otherwise digits_in (combinational mux).
- Reset mid-count returns the block to IDLE immediately. The time counter's own reset clears the digits; the controller does not pulse count_clear on reset.

Test Plan:
1. TICK_DIV=4, DEBOUNCE_CYCLES=3: press start/stop -> RUN after 2 sync + 3 debounce cycles; count_enable pulses every 4th cycle; 10 pulses take digits from 0000 to 0010.
2. Bounce: toggle btn_startstop every cycle for 10 cycles, then hold high -> exactly one ss_p, generated 3 stable cycles after the last edge; the state changes once.
3. Lap: RUN at 0123, press lap -> digits_out holds 0123 while digits_in advances to 0130; press lap again -> digits_out follows digits_in.
4. Stop/resume: stop with the prescaler at 2 -> no count_enable while STOPPED; after resume the first count_enable arrives 2 cycles later; clr_p in STOPPED -> single count_clear, state IDLE.
5. Saturation: digits_in forced to 9599 in RUN -> the next tick gives no count_enable, state STOPPED, running=0.
6. Async reset asserted in LAP between clock edges -> outputs 0 and state IDLE immediately; start/stop and clear pressed in the same cycle in STOPPED -> RUN with no count_clear.

Source files
------------

// File: rtl/stopwatch_controller.sv
// -----------------------------------------------------------------------------
// stopwatch_controller
//
// Control block for an M:SS.t stopwatch. It debounces the three board buttons,
// divides the system clock down to a tenth-second count strobe and runs the
// IDLE / RUN / LAP / STOPPED state machine. It also clears the external BCD
// time counter and freezes the displayed value while a lap is shown.
//
// Ports:
//   clock          in   system clock, all logic on the rising edge
//   reset          in   asynchronous active-low reset
//   btn_startstop  in   raw start/stop button (active-high, asynchronous)
//   btn_lap        in   raw lap button (active-high, asynchronous)
//   btn_clear      in   raw clear button (active-high, asynchronous)
//   digits_in      in   live BCD count {d3,d2,d1,d0} from the time counter
//   count_enable   out  one-cycle increment strobe to the time counter
//   count_clear    out  one-cycle clear strobe to the time counter
//   digits_out     out  value to display: live count, or the latched lap value
//   running        out  high in RUN and LAP
//   lapping        out  high in LAP
// -----------------------------------------------------------------------------
module stopwatch_controller #(
    parameter int unsigned TICK_DIV        = 10000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter logic [15:0] MAX_DIGITS      = 16'h9599
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_startstop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    input  logic [15:0] digits_in,
    output logic        count_enable,
    output logic        count_clear,
    output logic [15:0] digits_out,
    output logic        running,
    output logic        lapping
);

    localparam int NUM_BTN = 3;
    localparam int PW      = $clog2(TICK_DIV);
    localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);

    localparam int BTN_SS  = 0;
    localparam int BTN_LAP = 1;
    localparam int BTN_CLR = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_LAP     = 2'd2,
        S_STOPPED = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // Button path: synchroniser, debouncer, rising-edge press pulse
    // -------------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;

    assign btn_raw = {btn_clear, btn_lap, btn_startstop};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        logic          sync1_q;
        logic          sync2_q;
        logic          level_q;
        logic          press_q;
        logic [DW-1:0] cnt_q;
        logic          stable_done;

        assign stable_done = (cnt_q == DW'(DEBOUNCE_CYCLES - 1));

        // The counter only runs while the synchronised level differs from the
        // accepted level. Any bounce back to the accepted level zeroes it, so
        // each edge of the synchronised level restarts the stability window.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= btn_raw[g];
                sync2_q <= sync1_q;
                press_q <= 1'b0;
                if (sync2_q == level_q) begin
                    cnt_q <= '0;
                end else if (stable_done) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                    // Only a newly accepted high level is a press.
                    press_q <= sync2_q;
                end else begin
                    cnt_q <= cnt_q + DW'(1);
                end
            end
        end

        assign press[g] = press_q;
    end

    logic ss_p;
    logic lap_p;
    logic clr_p;

    assign ss_p  = press[BTN_SS];
    assign lap_p = press[BTN_LAP];
    assign clr_p = press[BTN_CLR];

    // -------------------------------------------------------------------------
    // State machine, prescaler, strobes and lap register
    // -------------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   lap_q,   lap_d;
    logic          ce_q,    ce_d;
    logic          clr_q,   clr_d;

    logic counting;
    logic tick;
    logic saturate;

    assign counting = (state_q == S_RUN) || (state_q == S_LAP);
    assign tick     = counting && (presc_q == PW'(TICK_DIV - 1));
    // A tick at full scale would wrap the counter; stop instead.
    assign saturate = tick && (digits_in == MAX_DIGITS);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        lap_d   = lap_q;
        ce_d    = tick && !saturate;
        clr_d   = 1'b0;

        // The prescaler holds outside RUN/LAP so a partial tenth survives a
        // stop/start.
        if (counting) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        // if/else chains give ss_p > lap_p > clr_p; losers are dropped.
        case (state_q)
            S_IDLE: begin
                if (ss_p) begin
                    state_d = S_RUN;
                end else if (clr_p) begin
                    clr_d   = 1'b1;
                    presc_d = '0;
                end
            end
            S_RUN: begin
                if (ss_p) begin
                    state_d = S_STOPPED;
                end else if (lap_p) begin
                    state_d = S_LAP;
                    lap_d   = digits_in;
                end
            end
            S_LAP: begin
                if (ss_p) begin
                    state_d = S_STOPPED;
                end else if (lap_p) begin
                    state_d = S_RUN;
                end
            end
            S_STOPPED: begin
                if (ss_p) begin
                    state_d = S_RUN;
                end else if (clr_p) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                    presc_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Saturation wins over any button in the same cycle.
        if (saturate) begin
            state_d = S_STOPPED;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            lap_q   <= '0;
            ce_q    <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            lap_q   <= lap_d;
            ce_q    <= ce_d;
            clr_q   <= clr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // ce_q is only ever set from RUN/LAP and clr_q only from IDLE/STOPPED, so
    // the two strobes can never coincide.
    assign count_enable = ce_q;
    assign count_clear  = clr_q;
    assign running      = counting;
    assign lapping      = (state_q == S_LAP);
    assign digits_out   = (state_q == S_LAP) ? lap_q : digits_in;

endmodule

// File: tb/tb_stopwatch_controller.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_controller
//
// Directed bench for stopwatch_controller with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// A small BCD time counter model sits on count_enable/count_clear and can be
// loaded directly to force digits_in. Inputs change and outputs are sampled
// on the falling clock edge; all expected values are hand-computed cycle
// positions relative to those falling edges.
// -----------------------------------------------------------------------------
module tb_stopwatch_controller;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        b_ss   = 1'b0;
    logic        b_lap  = 1'b0;
    logic        b_clr  = 1'b0;
    logic [15:0] dig    = '0;
    logic [15:0] ld_val = '0;
    logic        ld_en  = 1'b0;

    logic        ce;
    logic        cc;
    logic [15:0] dout;
    logic        run;
    logic        lap;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stopwatch_controller #(
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_CYCLES(DEB),
        .MAX_DIGITS     (16'h9599)
    ) dut (
        .clock        (clk),
        .reset        (rst_n),
        .btn_startstop(b_ss),
        .btn_lap      (b_lap),
        .btn_clear    (b_clr),
        .digits_in    (dig),
        .count_enable (ce),
        .count_clear  (cc),
        .digits_out   (dout),
        .running      (run),
        .lapping      (lap)
    );

    // BCD M:SS.t increment.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
        else begin
            r[3:0] = 4'd0;
            if (r[7:4] != 4'd9) r[7:4] = r[7:4] + 4'd1;
            else begin
                r[7:4] = 4'd0;
                if (r[11:8] != 4'd5) r[11:8] = r[11:8] + 4'd1;
                else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = (r[15:12] == 4'd9) ? 4'd0 : r[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Time counter model; a load stands in for forcing digits_in.
    always @(posedge clk) begin
        if (ld_en)   dig <= ld_val;
        else if (cc) dig <= '0;
        else if (ce) dig <= bcd_inc(dig);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_ss_rel();
        b_ss = 1'b1;
        step(8);
        b_ss = 1'b0;
        step(8);
    endtask

    initial begin
        int first, pulses, chg, at, ce_stop;
        logic prev;

        // ---- reset state
        step(1);
        chk("rst_ce",   ce,   0);
        chk("rst_cc",   cc,   0);
        chk("rst_run",  run,  0);
        chk("rst_lap",  lap,  0);
        chk("rst_dout", dout, 16'h0000);
        rst_n = 1'b1;
        step(1);                                   // n0

        // ---- T1: start, tick rate, ten counts
        b_ss = 1'b1;
        step(5); chk("t1_not_yet", run, 0);        // n5
        step(1); chk("t1_run",     run, 1);        // n6
        first = -1; pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (ce) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        chk("t1_first_ce", first,  4);
        chk("t1_pulses",   pulses, 10);
        step(1); chk("t1_digits", dout, 16'h0010); // n47
        b_ss = 1'b0;
        step(9);                                   // n56

        // ---- T2: bounce then hold -> single stop
        chg = 0; at = -1; ce_stop = 0; prev = run;
        for (int i = 0; i <= 24; i++) begin
            if (run != prev) begin
                chg++;
                at = i;
                prev = run;
            end
            if (i >= 16 && ce) ce_stop++;
            b_ss = (i < 10) ? ((i % 2) == 0) : 1'b1;
            step(1);
        end                                        // n81
        chk("t2_changes",  chg,     1);
        chk("t2_change_at", at,     16);
        chk("t2_no_ce",    ce_stop, 0);
        chk("t2_digits",   dout,    16'h0016);
        b_ss = 1'b0;
        step(7);                                   // n88

        // ---- T4a: resume, fractional tenth preserved (prescaler held at 2)
        b_ss = 1'b1;
        step(5); chk("t4_stopped", run, 0);        // n93
        step(1); chk("t4_resumed", run, 1);        // n94
        step(1); chk("t4_ce_early", ce, 0);        // n95
        step(1); chk("t4_ce",       ce, 1);        // n96
        step(1); chk("t4_digits", dout, 16'h0017); // n97
        b_ss = 1'b0;

        // ---- T3: lap freeze and release
        b_lap = 1'b1;
        step(4);                                   // n101
        ld_val = 16'h0123; ld_en = 1'b1;
        step(1); ld_en = 1'b0;                     // n102
        chk("t3_not_lap", lap, 0);
        step(1);                                   // n103
        chk("t3_lap",      lap,  1);
        chk("t3_hold",     dout, 16'h0123);
        b_lap = 1'b0;
        step(26);                                  // n129
        chk("t3_hold_late", dout, 16'h0123);
        chk("t3_live",      dig,  16'h0130);
        b_lap = 1'b1;
        step(5);                                   // n134
        chk("t3_still_lap", lap,  1);
        chk("t3_still_hold", dout, 16'h0123);
        step(1);                                   // n135
        chk("t3_unlap",   lap,  0);
        chk("t3_run",     run,  1);
        chk("t3_follow",  dout, 16'h0131);
        b_lap = 1'b0;

        // ---- T4b: stop then clear in STOPPED
        step(1); b_ss = 1'b1;                      // n136
        step(5); chk("t4_run_pre", run, 0 + 1);    // n141
        step(1); chk("t4_stop", run, 0);           // n142
        b_ss = 1'b0;
        step(8); b_clr = 1'b1;                     // n150
        step(5); chk("t4_cc_early", cc, 0);        // n155
        step(1);                                   // n156
        chk("t4_cc",      cc,  1);
        chk("t4_idle",    run, 0);
        b_clr = 1'b0;
        step(1);                                   // n157
        chk("t4_cc_once", cc,   0);
        chk("t4_cleared", dout, 16'h0000);

        // ---- T5: saturation at 9:59.9
        step(8); b_ss = 1'b1;                      // n165
        step(6); chk("t5_run", run, 1);            // n171
        b_ss = 1'b0;
        step(1); ld_val = 16'h9599; ld_en = 1'b1;  // n172
        step(1); ld_en = 1'b0;                     // n173
        step(1);                                   // n174
        chk("t5_run_tick", run, 1);
        chk("t5_ce_tick",  ce,  0);
        step(1);                                   // n175
        chk("t5_stopped", run,  0);
        chk("t5_no_ce",   ce,   0);
        chk("t5_digits",  dout, 16'h9599);

        // ---- T6a: async reset while in LAP
        step(3); ld_val = 16'h0500; ld_en = 1'b1;  // n178
        step(1); ld_en = 1'b0;                     // n179
        step(1); b_ss = 1'b1;                      // n180
        step(6); chk("t6_run", run, 1);            // n186
        b_ss = 1'b0; b_lap = 1'b1;
        step(6);                                   // n192
        chk("t6_lap",  lap,  1);
        chk("t6_hold", dout, 16'h0501);
        b_lap = 1'b0;
        ld_val = 16'h0777; ld_en = 1'b1;
        step(1); ld_en = 1'b0;                     // n193
        chk("t6_hold2", dout, 16'h0501);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_run",  run,  0);
        chk("t6_rst_lap",  lap,  0);
        chk("t6_rst_ce",   ce,   0);
        chk("t6_rst_cc",   cc,   0);
        chk("t6_rst_dout", dout, 16'h0777);
        step(1); rst_n = 1'b1;                     // n194

        // ---- IDLE clear: one count_clear pulse
        step(1); b_clr = 1'b1;                     // n195
        pulses = 0; at = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (cc) begin
                pulses++;
                at = i;
            end
        end
        chk("idle_cc_cnt", pulses, 1);
        chk("idle_cc_at",  at,     6);
        chk("idle_run",    run,    0);
        chk("idle_dout",   dout,   16'h0000);
        b_clr = 1'b0;
        step(8);

        // ---- T6b: start/stop and clear together in STOPPED
        press_ss_rel();
        chk("t6b_run", run, 1);
        press_ss_rel();
        chk("t6b_stopped", run, 0);
        b_ss = 1'b1; b_clr = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (cc) pulses++;
        end
        chk("t6b_no_cc", pulses, 0);
        chk("t6b_run2",  run,    1);
        chk("t6b_nolap", lap,    0);
        b_ss = 1'b0; b_clr = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
